comparador_ventana: RTL and testbench
=====================================

Name: comparador_ventana

Overview:
- Streaming 1-D sliding-window max/min filter for the image-filter datapath; successor to the fixed 5-input combinational comparator.
- Keeps the last WIN accepted pixels of the current line and emits their maximum (dilation) or minimum (erosion) for every accepted pixel.
- Sits between the pixel source and the frame writer.
- Window width, data width and operating mode are generalised; line-start edge replication is new.

Parameters:
- DATA_W, 8, pixel width in bits (1..16).
- WIN, 5, window length in pixels (2..9).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- modo  input  1  0 = maximum (dilation), 1 = minimum (erosion); sampled only at line start.
- in_valid  input  1  in_dato/in_sol valid this cycle; no backpressure, every valid beat is accepted.
- in_sol  input  1  start of line, qualified by in_valid.
- in_dato  input  DATA_W  unsigned pixel.
- out_valid  output  1  out_dato/out_sol valid this cycle.
- out_sol  output  1  in_sol of the corresponding input beat, delayed.
- out_dato  output  DATA_W  max/min of the current window.
- modo_activo  output  1  mode latched for the current line.

Behaviour:
- Reset (synchronous, checked before all else):
  - out_valid=0, out_sol=0, out_dato=0, modo_activo=0.
  - All WIN window registers = 0.
  - Internal flag primero=1.
  - Reset during a line discards the line; nothing is emitted for beats presented in the reset cycle.
- Accepted beat: in_valid=1 and reset=0. Line start: accepted beat with in_sol=1 or primero=1. primero clears on the first accepted beat after reset.
- Line start:
  - All WIN window registers load in_dato (edge replication).
  - modo_activo <= modo.
  - Window reduction uses in_dato for all entries, so out_dato = in_dato.
- Non-start accepted beat:
  - Window shifts by one; the oldest entry is discarded; in_dato enters at position 0.
  - modo_activo holds. modo changes mid-line are ignored until the next line start.
- Reduction:
  - Unsigned compare over the post-update window (the WIN entries including the new sample).
  - Reduction mode = modo_activo, or the incoming modo on a line-start beat.
  - Ties are irrelevant: the value is returned.
  - No arithmetic growth; output width = DATA_W.
- Latency: exactly 1 cycle. On the edge that accepts beat n, register out_dato, out_sol=(line start), out_valid=1. out_valid is visible the following cycle.
- Idle cycles (in_valid=0):
  - Window and modo_activo hold.
  - out_valid=0 next cycle; out_dato holds its last value; out_sol=0.
  - in_sol with in_valid=0 is ignored.
- Back-to-back beats give one output per cycle, sustained throughput 1 pixel/clk.
- Reduction may be a balanced comparator tree but must meet 1-cycle latency. No extra pipeline stages.

Test Plan:
- Reset then max mode, WIN=5, DATA_W=8. Beats (sol on first) 0x33,0x80,0x1F,0x80,0x00 -> out_dato 0x33,0x80,0x80,0x80,0x80; out_sol 1,0,0,0,0; each 1 cycle after its input.
- Same sequence with modo=1 -> out_dato 0x33,0x33,0x1F,0x1F,0x00; modo_activo=1.
- Eviction, max mode: sol 0xFF, then five 0x00 -> outputs 0xFF,0xFF,0xFF,0xFF,0xFF,0x00.
- Mid-line mode change: line started with modo=0, flip modo=1 mid-line -> max behaviour continues, modo_activo stays 0. Next sol beat 0x10 -> out_dato 0x10, modo_activo=1.
- Gaps plus reset:
  - Insert in_valid=0 cycles, including one with in_sol=1 -> out_valid=0 on those cycles, window unchanged, results identical to the gap-free run.
  - Assert reset mid-line -> next-cycle outputs all 0.
  - First beat after reset 0x05 without in_sol -> out_dato 0x05, out_sol=1.
- Parameter sweep WIN=2 and WIN=9, DATA_W=12: random streams with random sols and gaps, checked against a software model (max/min over the last WIN samples with line-start replication); zero mismatches.

Source files
------------

// File: rtl/comparador_ventana.sv
// Streaming 1-D sliding-window max/min filter (dilation/erosion) over the last
// WIN accepted pixels of the current line, with edge replication at line start.
module comparador_ventana #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WIN    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              modo,
    input  logic              in_valid,
    input  logic              in_sol,
    input  logic [DATA_W-1:0] in_dato,
    output logic              out_valid,
    output logic              out_sol,
    output logic [DATA_W-1:0] out_dato,
    output logic              modo_activo
);

    logic [DATA_W-1:0] ventana [WIN];
    logic [DATA_W-1:0] nueva   [WIN];
    logic [DATA_W-1:0] reduccion;
    logic              primero;
    logic              inicio;
    logic              modo_red;

    // Post-update window: a line start replicates the incoming pixel into every slot.
    always_comb begin
        inicio   = in_valid && (in_sol || primero);
        modo_red = inicio ? modo : modo_activo;
        nueva[0] = in_dato;
        for (int unsigned i = 1; i < WIN; i++) begin
            nueva[i] = inicio ? in_dato : ventana[i-1];
        end
    end

    always_comb begin
        reduccion = nueva[0];
        for (int unsigned i = 1; i < WIN; i++) begin
            if (modo_red ? (nueva[i] < reduccion) : (nueva[i] > reduccion)) begin
                reduccion = nueva[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_sol     <= 1'b0;
            out_dato    <= '0;
            modo_activo <= 1'b0;
            primero     <= 1'b1;
            for (int unsigned i = 0; i < WIN; i++) begin
                ventana[i] <= '0;
            end
        end else begin
            out_valid <= in_valid;
            out_sol   <= inicio;
            if (in_valid) begin
                for (int unsigned i = 0; i < WIN; i++) begin
                    ventana[i] <= nueva[i];
                end
                out_dato <= reduccion;
                primero  <= 1'b0;
                if (inicio) begin
                    modo_activo <= modo;
                end
            end
        end
    end

endmodule

// File: tb/tb_comparador_ventana.sv
// Scoreboard bench: directed WIN=5/DATA_W=8 sequences plus random streams on
// WIN=2 and WIN=9 with DATA_W=12, checked against a behavioural window model.
module tb_comparador_ventana;

    typedef struct packed {
        logic        v;
        logic        sol;
        logic [15:0] dato;
        logic        ma;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIN=5, DATA_W=8 instance
    logic       r5 = 1'b0, m5 = 1'b0, v5 = 1'b0, s5 = 1'b0;
    logic [7:0] d5 = '0;
    logic       ov5, os5, oa5;
    logic [7:0] od5;

    // DATA_W=12 instances share stimulus
    logic        r12 = 1'b0, m12 = 1'b0, v12 = 1'b0, s12 = 1'b0;
    logic [11:0] d12 = '0;
    logic        ov2, os2, oa2, ov9, os9, oa9;
    logic [11:0] od2, od9;

    comparador_ventana #(.DATA_W(8), .WIN(5)) u5 (
        .clk(clk), .reset(r5), .modo(m5), .in_valid(v5), .in_sol(s5), .in_dato(d5),
        .out_valid(ov5), .out_sol(os5), .out_dato(od5), .modo_activo(oa5)
    );
    comparador_ventana #(.DATA_W(12), .WIN(2)) u2 (
        .clk(clk), .reset(r12), .modo(m12), .in_valid(v12), .in_sol(s12), .in_dato(d12),
        .out_valid(ov2), .out_sol(os2), .out_dato(od2), .modo_activo(oa2)
    );
    comparador_ventana #(.DATA_W(12), .WIN(9)) u9 (
        .clk(clk), .reset(r12), .modo(m12), .in_valid(v12), .in_sol(s12), .in_dato(d12),
        .out_valid(ov9), .out_sol(os9), .out_dato(od9), .modo_activo(oa9)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q5[$], q2[$], q9[$];

    logic [15:0] mw [3][9];
    logic        mprim [3];
    logic        mmodo [3];
    logic [15:0] mout  [3];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference: max/min over the last w accepted samples, replicated at line start.
    task automatic modelo(input int k, input int w, input logic rst, input logic v,
                          input logic s, input logic m, input logic [15:0] d);
        exp_t        e;
        logic        ini;
        logic        mr;
        logic [15:0] red;
        if (rst) begin
            for (int i = 0; i < 9; i++) mw[k][i] = '0;
            mprim[k] = 1'b1;
            mmodo[k] = 1'b0;
            mout[k]  = '0;
            e = '{v: 1'b0, sol: 1'b0, dato: 16'h0, ma: 1'b0};
        end else if (v) begin
            ini = s || mprim[k];
            mr  = ini ? m : mmodo[k];
            if (ini) begin
                for (int i = 0; i < w; i++) mw[k][i] = d;
            end else begin
                for (int i = w - 1; i > 0; i--) mw[k][i] = mw[k][i-1];
                mw[k][0] = d;
            end
            red = mw[k][0];
            for (int i = 1; i < w; i++) begin
                if (mr ? (mw[k][i] < red) : (mw[k][i] > red)) red = mw[k][i];
            end
            mout[k]  = red;
            mprim[k] = 1'b0;
            if (ini) mmodo[k] = m;
            e = '{v: 1'b1, sol: ini, dato: red, ma: mmodo[k]};
        end else begin
            e = '{v: 1'b0, sol: 1'b0, dato: mout[k], ma: mmodo[k]};
        end
        case (k)
            0:       q5.push_back(e);
            1:       q2.push_back(e);
            default: q9.push_back(e);
        endcase
    endtask

    task automatic comparar(input string tag, input exp_t e, input logic v, input logic s,
                            input logic [15:0] d, input logic a);
        chk({tag, ".valid"}, {15'h0, v}, {15'h0, e.v});
        chk({tag, ".sol"},   {15'h0, s}, {15'h0, e.sol});
        chk({tag, ".dato"},  d, e.dato);
        chk({tag, ".modo"},  {15'h0, a}, {15'h0, e.ma});
    endtask

    // One clock: push expectations for the currently driven inputs, then compare.
    task automatic ciclo();
        exp_t e;
        modelo(0, 5, r5,  v5,  s5,  m5,  {8'h0, d5});
        modelo(1, 2, r12, v12, s12, m12, {4'h0, d12});
        modelo(2, 9, r12, v12, s12, m12, {4'h0, d12});
        @(posedge clk);
        #1;
        if (q5.size() == 0 || q2.size() == 0 || q9.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL cola observed=empty expected=entry");
        end else begin
            e = q5.pop_front(); comparar("w5", e, ov5, os5, {8'h0, od5}, oa5);
            e = q2.pop_front(); comparar("w2", e, ov2, os2, {4'h0, od2}, oa2);
            e = q9.pop_front(); comparar("w9", e, ov9, os9, {4'h0, od9}, oa9);
        end
    endtask

    // Directed beat on the WIN=5 instance with hand-derived expected outputs.
    task automatic b5(input logic r, input logic v, input logic s, input logic [7:0] d,
                      input logic m, input logic ev, input logic es, input logic [7:0] ed,
                      input logic ea);
        r5 = r; v5 = v; s5 = s; d5 = d; m5 = m;
        ciclo();
        chk("dir.valid", {15'h0, ov5}, {15'h0, ev});
        chk("dir.sol",   {15'h0, os5}, {15'h0, es});
        chk("dir.dato",  {8'h0, od5},  {8'h0, ed});
        chk("dir.modo",  {15'h0, oa5}, {15'h0, ea});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset both groups
        r12 = 1'b1;
        b5(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        r12 = 1'b0;

        // Max mode
        b5(0, 1, 1, 8'h33, 0, 1, 1, 8'h33, 0);
        b5(0, 1, 0, 8'h80, 0, 1, 0, 8'h80, 0);
        b5(0, 1, 0, 8'h1F, 0, 1, 0, 8'h80, 0);
        b5(0, 1, 0, 8'h80, 0, 1, 0, 8'h80, 0);
        b5(0, 1, 0, 8'h00, 0, 1, 0, 8'h80, 0);

        // Min mode
        b5(0, 1, 1, 8'h33, 1, 1, 1, 8'h33, 1);
        b5(0, 1, 0, 8'h80, 1, 1, 0, 8'h33, 1);
        b5(0, 1, 0, 8'h1F, 1, 1, 0, 8'h1F, 1);
        b5(0, 1, 0, 8'h80, 1, 1, 0, 8'h1F, 1);
        b5(0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 1);

        // Eviction of the start pixel after WIN samples
        b5(0, 1, 1, 8'hFF, 0, 1, 1, 8'hFF, 0);
        b5(0, 1, 0, 8'h00, 0, 1, 0, 8'hFF, 0);
        b5(0, 1, 0, 8'h00, 0, 1, 0, 8'hFF, 0);
        b5(0, 1, 0, 8'h00, 0, 1, 0, 8'hFF, 0);
        b5(0, 1, 0, 8'h00, 0, 1, 0, 8'hFF, 0);
        b5(0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0);

        // Mode change mid-line is deferred to the next line start
        b5(0, 1, 1, 8'h10, 0, 1, 1, 8'h10, 0);
        b5(0, 1, 0, 8'h20, 1, 1, 0, 8'h20, 0);
        b5(0, 1, 0, 8'h05, 1, 1, 0, 8'h20, 0);
        b5(0, 1, 1, 8'h10, 1, 1, 1, 8'h10, 1);

        // Gaps, one carrying in_sol and junk data
        b5(0, 1, 1, 8'h33, 0, 1, 1, 8'h33, 0);
        b5(0, 0, 1, 8'hAA, 0, 0, 0, 8'h33, 0);
        b5(0, 1, 0, 8'h80, 0, 1, 0, 8'h80, 0);
        b5(0, 0, 0, 8'hAA, 1, 0, 0, 8'h80, 0);
        b5(0, 1, 0, 8'h1F, 0, 1, 0, 8'h80, 0);
        b5(0, 1, 0, 8'h80, 0, 1, 0, 8'h80, 0);
        b5(0, 0, 1, 8'hFF, 0, 0, 0, 8'h80, 0);
        b5(0, 1, 0, 8'h00, 0, 1, 0, 8'h80, 0);

        // Reset mid-line with a valid beat present
        b5(0, 1, 1, 8'h44, 1, 1, 1, 8'h44, 1);
        b5(0, 1, 0, 8'h55, 1, 1, 0, 8'h44, 1);
        b5(1, 1, 0, 8'h99, 1, 0, 0, 8'h00, 0);

        // First beat after reset starts a line without in_sol
        b5(0, 1, 0, 8'h05, 0, 1, 1, 8'h05, 0);
        b5(0, 1, 0, 8'h03, 0, 1, 0, 8'h05, 0);
        b5(0, 0, 0, 8'h00, 0, 0, 0, 8'h05, 0);

        // Random streams on the DATA_W=12 instances
        r5 = 1'b0; v5 = 1'b0; s5 = 1'b0; d5 = '0; m5 = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            r12 = ($urandom_range(0, 149) == 0);
            v12 = ($urandom_range(0, 3) != 0);
            s12 = ($urandom_range(0, 11) == 0);
            m12 = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0:       d12 = 12'h000;
                1:       d12 = 12'hFFF;
                default: d12 = 12'($urandom_range(0, 4095));
            endcase
            ciclo();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
